perf_counter_bank: RTL
======================

// Module: perf_counter_bank
// PURPOSE
//  Parametrised performance-statistics unit for the 5-stage MIPS core; successor to the fixed
//  four-counter statistics block. Counts cycles plus NUM_EVT qualified pipeline events with
//  wrap or saturate mode and sticky overflow. Offers snapshot/read-and-clear readout through a
//  select port. Captures syscall print values into a display register and a history FIFO.
// PARAMETERS
//  NUM_EVT     4   number of event channels (1..15); channel 0 = cycle counter, i+1 = evt[i]
//  CNT_W       32  counter width in bits (8..64)
//  SAT         0   0: counters wrap to 0; 1: counters saturate at all-ones
//  HIST_DEPTH  4   syscall history FIFO depth, power of two, >=2
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  run        in   1              count qualifier (core not halted)
//  evt        in   NUM_EVT        event strobes, one per channel, sampled when run=1
//  clr        in   1              synchronous clear of live counters and ovf flags
//  snap       in   1              copy live counters into shadow bank
//  rd_sel     in   4              shadow bank index: 0 = cycles, 1..NUM_EVT = events
//  rd_data    out  CNT_W          shadow[rd_sel], combinational; 0 if rd_sel > NUM_EVT
//  cycles     out  CNT_W          live cycle counter
//  ovf        out  NUM_EVT+1      sticky overflow per channel (bit 0 = cycles)
//  sys_valid  in   1              syscall in WB stage
//  sys_a      in   32             $v0 value (service code)
//  sys_b      in   32             $a0 value (print payload)
//  disp_data  out  32             last displayed syscall payload
//  hist_valid out  1              history FIFO not empty
//  hist_data  out  32             oldest history entry (first-word-fall-through)
//  hist_pop   in   1              consume head entry when hist_valid=1
//  hist_drop  out  1              sticky: an entry was overwritten while FIFO was full
// BEHAVIOUR
//  Reset: all counters, shadows, ovf, disp_data, FIFO pointers/count, hist_drop <= 0.
//    Async reset clears regardless of clk, including mid-snapshot or mid-push.
//  Counting: on each posedge, channel 0 increments if run. Channel i+1 increments if run & evt[i].
//    Result is visible one cycle later. run=0 freezes all live counters.
//  Width: increment is CNT_W-bit.
//    At all-ones with an increment pending: SAT=0 wraps to 0; SAT=1 holds all-ones.
//    In both modes ovf[ch] is set and stays set until clr or rst.
//  clr: live counters and ovf <= 0. clr beats a simultaneous increment (result 0, not 1).
//    Shadow bank is unaffected.
//  snap: each shadow <= live value as it stood before this edge, excluding this cycle's increment.
//    snap+clr in the same cycle = read-and-clear: shadow gets old value, live becomes 0,
//    and no count is lost or double-counted across the pair.
//  Display: show = sys_valid & sys_a!=10 & sys_a!=50. On show: disp_data <= sys_b and sys_b is pushed.
//  FIFO: pop is honoured only if hist_valid. Empty pop is ignored with no underflow.
//    Push when full, no pop: oldest entry discarded, new entry written, count unchanged,
//    hist_drop <= 1.
//    Push+pop when full: normal pop+push, no drop. Push+pop when empty: entry is stored, pop ignored.
//    Pointers wrap modulo HIST_DEPTH. hist_drop clears only on rst.
//  rd_data and hist_data are combinational from registers, with no added latency.
// TESTING
//  T1 reset: rst pulse mid-count (cycles=37) -> next sample all outputs 0, hist_valid=0, ovf=0.
//  T2 events: run=1 for 10 cycles, evt[0] high 4 of them, evt[1] on 2 cycles with run=0
//     -> cycles=10, ch1=4, ch2=0.
//  T3 overflow (CNT_W=8): run 257 cycles. SAT=0 -> cycles=1, ovf[0]=1. SAT=1 -> cycles=255, ovf[0]=1.
//  T4 read-and-clear: cycles=100, assert snap+clr with run=1
//     -> rd_sel=0 reads 100, cycles=0 next edge, then 1.
//  T5 syscall filter: (a=1,b=7),(a=10,b=9),(a=50,b=3),(a=4,b=5)
//     -> disp_data=5, FIFO holds 7,5. Pop twice -> hist_valid=0.
//  T6 FIFO full (DEPTH=4): push 1..5 without pop -> head=2, hist_drop=1.
//     Push+pop when full -> no further drop, count stays 4.

Source files
------------

// File: rtl/perf_counter_bank_if.sv
// Control, readout and syscall-history signals of the performance counter bank.
// Latency: none; this is pure wiring between the driver and the bank.
// Backpressure: none; a history pop is simply ignored while the FIFO is empty.
interface perf_counter_bank_if #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32
);
    logic               i_run;
    logic [NUM_EVT-1:0] i_evt;
    logic               i_clr;
    logic               i_snap;
    logic [3:0]         i_rd_sel;
    logic [CNT_W-1:0]   o_rd_data;
    logic [CNT_W-1:0]   o_cycles;
    logic [NUM_EVT:0]   o_ovf;
    logic               i_sys_valid;
    logic [31:0]        i_sys_a;
    logic [31:0]        i_sys_b;
    logic [31:0]        o_disp_data;
    logic               o_hist_valid;
    logic [31:0]        o_hist_data;
    logic               i_hist_pop;
    logic               o_hist_drop;

    // The counter bank itself.
    modport slave (
        input  i_run, i_evt, i_clr, i_snap, i_rd_sel,
        input  i_sys_valid, i_sys_a, i_sys_b, i_hist_pop,
        output o_rd_data, o_cycles, o_ovf,
        output o_disp_data, o_hist_valid, o_hist_data, o_hist_drop
    );

    // The core or debug logic that drives the bank.
    modport master (
        output i_run, i_evt, i_clr, i_snap, i_rd_sel,
        output i_sys_valid, i_sys_a, i_sys_b, i_hist_pop,
        input  o_rd_data, o_cycles, o_ovf,
        input  o_disp_data, o_hist_valid, o_hist_data, o_hist_drop
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Cycle and event counters with snapshot readout, plus a syscall display register and history FIFO.
// Latency: counts, snapshots and pushes are visible 1 cycle later; rd_data and hist_data are combinational.
// Backpressure: none; a full history FIFO overwrites its oldest entry and sets a sticky drop flag.
module perf_counter_bank #(
    parameter int NUM_EVT    = 4,
    parameter int CNT_W      = 32,
    parameter int SAT        = 0,
    parameter int HIST_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    perf_counter_bank_if.slave bus
);
    localparam int NCH = NUM_EVT + 1;
    localparam int AW  = $clog2(HIST_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(HIST_DEPTH);

    // ---------------- counters ----------------
    logic [CNT_W-1:0] r_cnt    [NCH];
    logic [CNT_W-1:0] r_shadow [NCH];
    logic [NCH-1:0]   r_ovf;
    logic [NCH-1:0]   w_inc;
    logic [CNT_W-1:0] w_rd_data;

    // Channel 0 counts every running cycle; channel i+1 counts evt[i] while running.
    assign w_inc = {bus.i_evt & {NUM_EVT{bus.i_run}}, bus.i_run};

    // Live counters: clear wins over increment; at all-ones an increment wraps or holds and flags overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int ch = 0; ch < NCH; ch++) r_cnt[ch] <= '0;
            r_ovf <= '0;
        end else if (bus.i_clr) begin
            for (int ch = 0; ch < NCH; ch++) r_cnt[ch] <= '0;
            r_ovf <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (w_inc[ch]) begin
                    if (&r_cnt[ch]) begin
                        r_ovf[ch] <= 1'b1;
                        r_cnt[ch] <= (SAT != 0) ? r_cnt[ch] : '0;
                    end else begin
                        r_cnt[ch] <= r_cnt[ch] + 1'b1;
                    end
                end
            end
        end
    end

    // Shadow bank takes the pre-edge live values, so snap together with clr is a lossless read-and-clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int ch = 0; ch < NCH; ch++) r_shadow[ch] <= '0;
        end else if (bus.i_snap) begin
            for (int ch = 0; ch < NCH; ch++) r_shadow[ch] <= r_cnt[ch];
        end
    end

    // Shadow readout mux; out-of-range selects read as zero.
    always_comb begin
        w_rd_data = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (bus.i_rd_sel == 4'(ch)) w_rd_data = r_shadow[ch];
        end
    end

    assign bus.o_rd_data = w_rd_data;
    assign bus.o_cycles  = r_cnt[0];
    assign bus.o_ovf     = r_ovf;

    // ---------------- syscall display and history ----------------
    logic [31:0] r_disp;
    logic [31:0] r_mem [HIST_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          r_drop;
    logic          w_show, w_empty, w_full, w_pop;

    // Service codes 10 (exit) and 50 are control calls and never reach the display.
    assign w_show  = bus.i_sys_valid && (bus.i_sys_a != 32'd10) && (bus.i_sys_a != 32'd50);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = bus.i_hist_pop && !w_empty;

    // Display register holds the most recent shown payload.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_disp <= '0;
        else if (w_show) r_disp <= bus.i_sys_b;
    end

    // History storage; contents need no reset because reads are gated by the count.
    always_ff @(posedge i_clk) begin
        if (w_show) r_mem[r_wptr] <= bus.i_sys_b;
    end

    // FIFO bookkeeping: a push into a full FIFO with no pop evicts the head and sets the sticky drop flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_show) r_wptr <= r_wptr + 1'b1;
            if (w_pop || (w_show && w_full)) r_rptr <= r_rptr + 1'b1;
            if (w_show && !w_pop && !w_full) r_count <= r_count + 1'b1;
            else if (!w_show && w_pop) r_count <= r_count - 1'b1;
            if (w_show && !w_pop && w_full) r_drop <= 1'b1;
        end
    end

    assign bus.o_disp_data  = r_disp;
    assign bus.o_hist_valid = !w_empty;
    assign bus.o_hist_data  = w_empty ? 32'd0 : r_mem[r_rptr];
    assign bus.o_hist_drop  = r_drop;
endmodule
